// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with sized accesses over a req/gnt/rvalid bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid_i,
  input  logic                mem_read_c_i,
  input  logic                mem_write_c_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                stall_o,
  output logic [DATA_W-1:0]   load_data_o,
  output logic                done_o,
  output logic                exc_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_d;
  logic accept, illegal, trap, uns_q, we_q, exc_q, sign;
  logic [1:0] size_q;
  logic [3:0] nb, nb_q;
  logic [OFF_W-1:0] off, off_a, off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_q, rep, shifted, ext;
  logic [BYTES-1:0] strb, strb_q;
  assign accept = op_valid_i & (mem_read_c_i | mem_write_c_i);
  assign nb = 4'd1 << funct3_i[1:0];
  assign nb_q = 4'd1 << size_q;
  assign illegal = 32'(funct3_i[1:0]) > OFF_W;
  assign off = addr_i[OFF_W-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
  assign off_a = off;
  assign trap = illegal | ((32'(off) & (32'(nb) - 32'd1)) != 32'd0);
`else
  assign off_a = off & ~OFF_W'(nb - 4'd1);
  assign trap = illegal;
`endif
  assign strb = mem_write_c_i ? BYTES'(((32'd1 << nb) - 32'd1) << off_a) : '0;
  always_comb begin
    rep = '0;
    for (int b = 0; b < BYTES; b++) rep[8*b +: 8] = wdata_i[8*(b & (int'(nb) - 1)) +: 8];
  end
  // Sign source is the top bit of the accessed field after shifting it down to lane 0.
  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    sign = ~uns_q & (32'(size_q) < OFF_W) & shifted[8*int'(nb_q)-1];
    ext = shifted;
    for (int i = 0; i < DATA_W; i++) if (i >= 8*int'(nb_q)) ext[i] = sign;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = accept ? (trap ? DONE : REQ) : IDLE;
      REQ:  state_d = mem_gnt_i ? WAIT : REQ;
      WAIT: state_d = mem_rvalid_i ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      we_q <= 1'b0;
      size_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      exc_q <= 1'b0;
      load_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && accept) begin
        addr_q <= {addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        wdata_q <= mem_write_c_i ? rep : '0;
        strb_q <= strb;
        we_q <= mem_write_c_i;
        size_q <= funct3_i[1:0];
        uns_q <= funct3_i[2];
        off_q <= off_a;
        exc_q <= trap;
        load_q <= '0;
      end
      if (state == WAIT && mem_rvalid_i) begin
        exc_q <= mem_err_i;
        load_q <= (mem_err_i | we_q) ? '0 : ext;
      end
    end
  assign stall_o = (state == IDLE & accept) | (state == REQ) | (state == WAIT);
  assign mem_req_o = state == REQ;
  assign mem_we_o = (state == REQ) & we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = strb_q;
  assign done_o = state == DONE;
  assign exc_o = (state == DONE) & exc_q;
  assign load_data_o = load_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized and directed checks of mem_stage_lsu against a behavioural model.
module tb_mem_stage_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic op_valid = 1'b0, rd_c = 1'b0, wr_c = 1'b0, gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic stall, done, exc, req, we;
  logic [31:0] load, maddr, mwdata;
  logic [3:0] wstrb;
  int vecs = 0, errs = 0;
  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid), .mem_read_c_i(rd_c), .mem_write_c_i(wr_c),
    .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .load_data_o(load),
    .done_o(done), .exc_o(exc), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_wstrb_o(wstrb), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .mem_err_i(err)
  );
  always #5 clk = ~clk;
  task automatic check_idle_outputs(input string tag);
    vecs++; if ({req, we, done, exc, stall} !== 5'b0) begin errs++; $display("FAIL %s ctrl got=%b want=00000", tag, {req, we, done, exc, stall}); end
    vecs++; if (maddr !== 0 || mwdata !== 0 || wstrb !== 0 || load !== 0) begin errs++; $display("FAIL %s regs got addr=%h wdata=%h strb=%b load=%h want all 0", tag, maddr, mwdata, wstrb, load); end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask
  // One full access; the bus model grants after gd REQ cycles and responds rdl cycles later.
  task automatic access(input string tag, input bit w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input bit e, input int gd, input int rdl);
    int nb, off, eoff, exp_cyc, cyc, reqn, waitn;
    bit trap, mis, fin, seen;
    logic [3:0] e_strb;
    logic [31:0] e_wd, e_ld;
    longint unsigned mask, v;
    nb = 1 << fn[1:0];
    off = int'(a % 4);
    mis = (off % nb) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = fn[1:0] == 2'd3 || mis;
    eoff = off;
`else
    trap = fn[1:0] == 2'd3;
    eoff = off - off % nb;
`endif
    e_strb = w ? 4'((((1 << nb) - 1) << eoff)) : 4'd0;
    for (int b = 0; b < 4; b++) e_wd[8*b +: 8] = wd[8*(b % nb) +: 8];
    mask = (64'd1 << (8 * nb)) - 1;
    v = (64'(rd) >> (8 * eoff)) & mask;
    if (!fn[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    e_ld = e ? 32'd0 : v[31:0];
    exp_cyc = trap ? 1 : gd + rdl + 3;
    @(negedge clk);
    op_valid = 1'b1; rd_c = !w; wr_c = w; f3 = fn; addr = a; wdata = wd;
    cyc = 0; reqn = 0; waitn = 0; fin = 0; seen = 0;
    while (cyc < 64) begin
      #1;
      gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = ~rd;
      if (done) begin
        fin = 1;
        vecs++; if (cyc !== exp_cyc) begin errs++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc, exp_cyc); end
        vecs++; if (exc !== (trap | e) || stall !== 1'b0) begin errs++; $display("FAIL %s done exc/stall got=%b%b want=%b0", tag, exc, stall, trap | e); end
        if (!w && !trap) begin
          vecs++; if (load !== e_ld) begin errs++; $display("FAIL %s load got=%h want=%h", tag, load, e_ld); end
        end
        break;
      end
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL %s stall cyc=%0d got=0 want=1", tag, cyc); end
      if (req) begin
        if (!seen) begin
          vecs++; if (maddr !== a - 32'(off) || wstrb !== e_strb || we !== w) begin errs++; $display("FAIL %s bus got addr=%h strb=%b we=%b want addr=%h strb=%b we=%b", tag, maddr, wstrb, we, a - 32'(off), e_strb, w); end
          if (w) begin
            vecs++; if (mwdata !== e_wd) begin errs++; $display("FAIL %s wdata got=%h want=%h", tag, mwdata, e_wd); end
          end
        end
        seen = 1;
        if (reqn == gd) begin gnt = 1'b1; rvalid = 1'b1; err = 1'b1; end
        reqn++;
      end else if (seen) begin
        if (waitn == rdl) begin rvalid = 1'b1; rdata = rd; err = e; end
        waitn++;
      end
      @(negedge clk);
      cyc++;
    end
    vecs++; if (!fin) begin errs++; $display("FAIL %s timeout got=no done want=done", tag); end
    vecs++; if (seen === trap) begin errs++; $display("FAIL %s req_seen got=%b want=%b", tag, seen, !trap); end
    op_valid = 1'b0; rd_c = 1'b0; wr_c = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    @(negedge clk); #1;
    vecs++; if (done !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL %s after got done=%b stall=%b want 0 0", tag, done, stall); end
  endtask
  task automatic test_directed;
    access("sb", 1, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 0, 0, 0);
    access("lb", 0, 3'b000, 32'h2001, 32'h0, 32'h0000_80FF, 0, 0, 0);
    access("lbu", 0, 3'b100, 32'h2001, 32'h0, 32'h0000_80FF, 0, 0, 0);
    access("lh_slow_gnt", 0, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 3, 0, 0);
    access("lhu", 0, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 0, 2, 0);
    access("lw_misaligned", 0, 3'b010, 32'h3002, 32'h0, 32'h1234_5678, 0, 0, 0);
    access("sh_hi", 1, 3'b001, 32'h5002, 32'hDEAD_BEEF, 32'h0, 1, 1, 0);
    access("sw_err", 1, 3'b010, 32'h4000, 32'hCAFE_F00D, 32'h0, 0, 0, 1);
    access("lw_err", 0, 3'b010, 32'h4004, 32'h0, 32'hFFFF_FFFF, 2, 1, 1);
    access("ld_illegal", 0, 3'b011, 32'h6000, 32'h0, 32'h0, 0, 0, 0);
  endtask
  task automatic test_no_mem_op;
    @(negedge clk);
    op_valid = 1'b1; rd_c = 1'b0; wr_c = 1'b0; addr = 32'h7000;
    repeat (3) begin
      #1;
      vecs++; if ({stall, req, done} !== 3'b000) begin errs++; $display("FAIL add got stall/req/done=%b want=000", {stall, req, done}); end
      @(negedge clk);
    end
    op_valid = 1'b0;
  endtask
  // Reset lands mid-access (REQ or WAIT); a later response must not produce done.
  task automatic test_reset_mid(input bit in_wait);
    @(negedge clk);
    op_valid = 1'b1; rd_c = 1'b1; f3 = 3'b010; addr = 32'h8004;
    @(negedge clk); #1;
    vecs++; if (req !== 1'b1) begin errs++; $display("FAIL rst_mid req got=%b want=1", req); end
    if (in_wait) begin
      gnt = 1'b1;
      @(negedge clk); #1;
      gnt = 1'b0;
    end
    op_valid = 1'b0; rd_c = 1'b0;
    rst_n = 1'b0;
    #1 check_idle_outputs(in_wait ? "rst_wait" : "rst_req");
    @(negedge clk);
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    rvalid = 1'b0;
    repeat (3) begin
      #1;
      vecs++; if ({done, req, stall} !== 3'b000) begin errs++; $display("FAIL rst_mid after got done/req/stall=%b want=000", {done, req, stall}); end
      @(negedge clk);
    end
  endtask
  task automatic test_random;
    for (int n = 0; n < 150; n++) begin
      access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_no_mem_op;
    test_reset_mid(0);
    test_reset_mid(1);
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
